// File: rtl/rob_pkg.sv
// Shared ROB/commit definitions: bus widths, commit FSM states, retire-bus payload.
package rob_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_STORE_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } commit_state_e;

  // Head-of-ROB entry as seen on the retire bus.
  typedef struct packed {
    logic [TAG_W-1:0]  rd_tag;
    logic [REG_W-1:0]  rd_reg;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
    logic              branch;
    logic              branch_taken;
    logic              store_ready;
  } retire_t;

endpackage

// File: rtl/commit_unit_if.sv
// Commit-stage bus bundle: ROB retire bus in, ARF write, store-commit handshake,
// flush redirect, tag free-list return and status out.
//   slave  : commit_unit side
//   master : ROB / store buffer / front-end side
interface commit_unit_if;
  import rob_pkg::*;

  logic              Retire_valid;
  logic [TAG_W-1:0]  Retire_rd_tag;
  logic [REG_W-1:0]  Retire_rd_reg;
  logic [DATA_W-1:0] Retire_data;
  logic [DATA_W-1:0] Retire_pc;
  logic              Retire_branch;
  logic              Retire_branch_taken;
  logic              Retire_store_ready;
  logic              Retire_ack;
  logic              Arf_we;
  logic [REG_W-1:0]  Arf_waddr;
  logic [DATA_W-1:0] Arf_wdata;
  logic              St_commit_valid;
  logic [TAG_W-1:0]  St_commit_tag;
  logic              St_commit_ack;
  logic              Flush;
  logic [DATA_W-1:0] Flush_pc;
  logic              Tag_free_valid;
  logic [TAG_W-1:0]  Tag_free_tag;
  logic [DATA_W-1:0] Last_commit_pc;
  logic [DATA_W-1:0] Commit_count;
  logic              Error;

  modport slave (
    input  Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
           Retire_branch, Retire_branch_taken, Retire_store_ready, St_commit_ack,
    output Retire_ack, Arf_we, Arf_waddr, Arf_wdata, St_commit_valid, St_commit_tag,
           Flush, Flush_pc, Tag_free_valid, Tag_free_tag, Last_commit_pc,
           Commit_count, Error
  );

  modport master (
    output Retire_valid, Retire_rd_tag, Retire_rd_reg, Retire_data, Retire_pc,
           Retire_branch, Retire_branch_taken, Retire_store_ready, St_commit_ack,
    input  Retire_ack, Arf_we, Arf_waddr, Arf_wdata, St_commit_valid, St_commit_tag,
           Flush, Flush_pc, Tag_free_valid, Tag_free_tag, Last_commit_pc,
           Commit_count, Error
  );

endinterface

// File: rtl/commit_wait_ctr.sv
// Loadable up/down counter shared by the flush hold-off and the store-ack timeout.
// Ports: clk, rst_n; load/load_val set the count; inc counts up (saturating at
// LIMIT); dec counts down to zero; done = count is zero; timeout = the next
// increment reaches LIMIT (or it has already been reached).
module commit_wait_ctr #(
  parameter int unsigned CNT_W = 7,
  parameter int unsigned LIMIT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic             done,
  output logic             timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && (cnt < CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done    = (cnt == '0);
  assign timeout = (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/commit_unit.sv
// In-order commit stage. Retires one ROB head entry per cycle: ALU results go to
// the ARF, stores are handed to the store buffer (valid/ack), taken branches
// raise a one-cycle flush with redirect PC and hold off retire for FLUSH_CYCLES.
// Ports: clock, reset (async, active-low), bus (commit_unit_if.slave).
module commit_unit
  import rob_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned ST_TIMEOUT   = 64
) (
  input  logic          clock,
  input  logic          reset,
  commit_unit_if.slave  bus
);

  localparam int unsigned CNT_MAX = (ST_TIMEOUT > FLUSH_CYCLES) ? ST_TIMEOUT : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  commit_state_e     state_q, state_d;
  retire_t           head;
  logic              accept;

  logic              arf_we_q, arf_we_d;
  logic [REG_W-1:0]  arf_waddr_q, arf_waddr_d;
  logic [DATA_W-1:0] arf_wdata_q, arf_wdata_d;
  logic              st_valid_q, st_valid_d;
  logic [TAG_W-1:0]  st_tag_q, st_tag_d;
  logic [DATA_W-1:0] st_pc_q, st_pc_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] flush_pc_q, flush_pc_d;
  logic              free_valid_q, free_valid_d;
  logic [TAG_W-1:0]  free_tag_q, free_tag_d;
  logic [DATA_W-1:0] last_pc_q, last_pc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              error_q, error_d;

  logic              ctr_load, ctr_inc, ctr_dec, ctr_done, ctr_timeout;
  logic [CNT_W-1:0]  ctr_load_val;

  assign head = '{rd_tag:       bus.Retire_rd_tag,
                  rd_reg:       bus.Retire_rd_reg,
                  data:         bus.Retire_data,
                  pc:           bus.Retire_pc,
                  branch:       bus.Retire_branch,
                  branch_taken: bus.Retire_branch_taken,
                  store_ready:  bus.Retire_store_ready};

  assign bus.Retire_ack = (state_q == ST_RUN);
  assign accept         = bus.Retire_valid && (state_q == ST_RUN);

  commit_wait_ctr #(
    .CNT_W (CNT_W),
    .LIMIT (ST_TIMEOUT)
  ) u_wait_ctr (
    .clk      (clock),
    .rst_n    (reset),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .inc      (ctr_inc),
    .dec      (ctr_dec),
    .done     (ctr_done),
    .timeout  (ctr_timeout)
  );

  // Next-state and next registered-output values.
  always_comb begin
    state_d      = state_q;
    arf_we_d     = 1'b0;
    arf_waddr_d  = arf_waddr_q;
    arf_wdata_d  = arf_wdata_q;
    st_valid_d   = st_valid_q;
    st_tag_d     = st_tag_q;
    st_pc_d      = st_pc_q;
    flush_d      = 1'b0;
    flush_pc_d   = flush_pc_q;
    free_valid_d = 1'b0;
    free_tag_d   = free_tag_q;
    last_pc_d    = last_pc_q;
    count_d      = count_q;
    error_d      = error_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    ctr_inc      = 1'b0;
    ctr_dec      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (head.store_ready) begin
            // Store wins over branch flags; commit completes on ack.
            st_valid_d = 1'b1;
            st_tag_d   = head.rd_tag;
            st_pc_d    = head.pc;
            ctr_load   = 1'b1;
            state_d    = ST_STORE_WAIT;
          end else begin
            free_valid_d = 1'b1;
            free_tag_d   = head.rd_tag;
            last_pc_d    = head.pc;
            count_d      = count_q + DATA_W'(1);
            if (head.branch && head.branch_taken) begin
              // Front end predicted not-taken: redirect to the target.
              flush_d      = 1'b1;
              flush_pc_d   = head.data;
              ctr_load     = 1'b1;
              ctr_load_val = CNT_W'(FLUSH_CYCLES - 1);
              state_d      = ST_FLUSH;
            end else if (!head.branch && (head.rd_reg != '0)) begin
              arf_we_d    = 1'b1;
              arf_waddr_d = head.rd_reg;
              arf_wdata_d = head.data;
            end
          end
        end
      end
      ST_STORE_WAIT: begin
        if (bus.St_commit_ack) begin
          st_valid_d   = 1'b0;
          free_valid_d = 1'b1;
          free_tag_d   = st_tag_q;
          last_pc_d    = st_pc_q;
          count_d      = count_q + DATA_W'(1);
          state_d      = ST_RUN;
        end else begin
          ctr_inc = 1'b1;
          if (ctr_timeout) begin
            error_d = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (ctr_done) begin
          state_d = ST_RUN;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      arf_we_q     <= 1'b0;
      arf_waddr_q  <= '0;
      arf_wdata_q  <= '0;
      st_valid_q   <= 1'b0;
      st_tag_q     <= '0;
      st_pc_q      <= '0;
      flush_q      <= 1'b0;
      flush_pc_q   <= '0;
      free_valid_q <= 1'b0;
      free_tag_q   <= '0;
      last_pc_q    <= '0;
      count_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      arf_we_q     <= arf_we_d;
      arf_waddr_q  <= arf_waddr_d;
      arf_wdata_q  <= arf_wdata_d;
      st_valid_q   <= st_valid_d;
      st_tag_q     <= st_tag_d;
      st_pc_q      <= st_pc_d;
      flush_q      <= flush_d;
      flush_pc_q   <= flush_pc_d;
      free_valid_q <= free_valid_d;
      free_tag_q   <= free_tag_d;
      last_pc_q    <= last_pc_d;
      count_q      <= count_d;
      error_q      <= error_d;
    end
  end

  assign bus.Arf_we          = arf_we_q;
  assign bus.Arf_waddr       = arf_waddr_q;
  assign bus.Arf_wdata       = arf_wdata_q;
  assign bus.St_commit_valid = st_valid_q;
  assign bus.St_commit_tag   = st_tag_q;
  assign bus.Flush           = flush_q;
  assign bus.Flush_pc        = flush_pc_q;
  assign bus.Tag_free_valid  = free_valid_q;
  assign bus.Tag_free_tag    = free_tag_q;
  assign bus.Last_commit_pc  = last_pc_q;
  assign bus.Commit_count    = count_q;
  assign bus.Error           = error_q;

endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: directed vector table, hand-written multi-cycle
// sequences (store wait, timeout, reset mid-wait) and a random phase, all
// checked against a transaction-level reference model.
module tb_commit_unit;
  import rob_pkg::*;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned ST_TIMEOUT   = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  commit_unit_if bus();

  commit_unit #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .ST_TIMEOUT   (ST_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  // Reference model: pending store, flush hold-off remaining, counters.
  bit               m_pend;
  logic [TAG_W-1:0] m_st_tag;
  logic [31:0]      m_st_pc;
  int unsigned      m_wait;
  int unsigned      m_flush_left;
  logic [31:0]      m_count;
  logic [31:0]      m_last_pc;
  bit               m_error;
  bit               e_we, e_st_valid, e_flush, e_free;
  logic [REG_W-1:0] e_waddr;
  logic [31:0]      e_wdata, e_flush_pc;
  logic [TAG_W-1:0] e_st_tag, e_free_tag;

  function automatic void model_reset();
    m_pend = 0; m_st_tag = '0; m_st_pc = '0; m_wait = 0; m_flush_left = 0;
    m_count = '0; m_last_pc = '0; m_error = 0;
    e_we = 0; e_st_valid = 0; e_flush = 0; e_free = 0;
    e_waddr = '0; e_wdata = '0; e_flush_pc = '0; e_st_tag = '0; e_free_tag = '0;
  endfunction

  // Advance the model by one clock edge using the inputs the bench is driving.
  function automatic void model_step();
    e_we = 0; e_flush = 0; e_free = 0;
    if (m_pend) begin
      if (bus.St_commit_ack) begin
        m_pend = 0; e_st_valid = 0;
        e_free = 1; e_free_tag = m_st_tag;
        m_count = m_count + 32'd1; m_last_pc = m_st_pc;
      end else begin
        m_wait++;
        if (m_wait >= ST_TIMEOUT) m_error = 1;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (bus.Retire_valid) begin
      if (bus.Retire_store_ready) begin
        m_pend = 1; m_wait = 0;
        m_st_tag = bus.Retire_rd_tag; m_st_pc = bus.Retire_pc;
        e_st_valid = 1; e_st_tag = bus.Retire_rd_tag;
      end else begin
        e_free = 1; e_free_tag = bus.Retire_rd_tag;
        m_count = m_count + 32'd1; m_last_pc = bus.Retire_pc;
        if (bus.Retire_branch && bus.Retire_branch_taken) begin
          e_flush = 1; e_flush_pc = bus.Retire_data; m_flush_left = FLUSH_CYCLES;
        end else if (!bus.Retire_branch && bus.Retire_rd_reg != '0) begin
          e_we = 1; e_waddr = bus.Retire_rd_reg; e_wdata = bus.Retire_data;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ack"}, 32'(bus.Retire_ack), 32'(!m_pend && m_flush_left == 0));
    chk({tag, ".arf_we"}, 32'(bus.Arf_we), 32'(e_we));
    if (e_we) begin
      chk({tag, ".arf_waddr"}, 32'(bus.Arf_waddr), 32'(e_waddr));
      chk({tag, ".arf_wdata"}, bus.Arf_wdata, e_wdata);
    end
    chk({tag, ".st_valid"}, 32'(bus.St_commit_valid), 32'(e_st_valid));
    if (e_st_valid) chk({tag, ".st_tag"}, 32'(bus.St_commit_tag), 32'(e_st_tag));
    chk({tag, ".flush"}, 32'(bus.Flush), 32'(e_flush));
    if (e_flush) chk({tag, ".flush_pc"}, bus.Flush_pc, e_flush_pc);
    chk({tag, ".free"}, 32'(bus.Tag_free_valid), 32'(e_free));
    if (e_free) chk({tag, ".free_tag"}, 32'(bus.Tag_free_tag), 32'(e_free_tag));
    chk({tag, ".last_pc"}, bus.Last_commit_pc, m_last_pc);
    chk({tag, ".count"}, bus.Commit_count, m_count);
    chk({tag, ".error"}, 32'(bus.Error), 32'(m_error));
  endtask

  task automatic drive(input bit v, input int tag, input int rg, input int data, input int pc,
                       input bit br, input bit tk, input bit st, input bit sa);
    bus.Retire_valid        = v;
    bus.Retire_rd_tag       = TAG_W'(tag);
    bus.Retire_rd_reg       = REG_W'(rg);
    bus.Retire_data         = 32'(data);
    bus.Retire_pc           = 32'(pc);
    bus.Retire_branch       = br;
    bus.Retire_branch_taken = tk;
    bus.Retire_store_ready  = st;
    bus.St_commit_ack       = sa;
  endtask

  task automatic idle(input bit sa);
    drive(0, 0, 0, 0, 0, 0, 0, 0, sa);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous clear, release away from an edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_model(tag);
    chk({tag, ".st_valid0"}, 32'(bus.St_commit_valid), 32'd0);
    chk({tag, ".count0"}, bus.Commit_count, 32'd0);
    chk({tag, ".error0"}, 32'(bus.Error), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    chk({tag, ".ack_after"}, 32'(bus.Retire_ack), 32'd1);
  endtask

  typedef struct {
    bit v; int tag; int rg; int data; int pc; bit br; bit tk; bit st; bit sa;
    bit e_ack; bit e_we; int e_waddr; int e_wdata; bit e_free; int e_ftag;
    bit e_flush; int e_fpc; bit e_stv; int e_sttag; int e_count;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1, 1, 4, 40,     'h1000, 0, 0, 0, 0,  1, 1, 4, 40, 1, 1,  0, 0,     0, 0, 1};
    vecs[1]  = '{1, 2, 5, 50,     'h1004, 0, 0, 0, 0,  1, 1, 5, 50, 1, 2,  0, 0,     0, 0, 2};
    vecs[2]  = '{1, 3, 0, 60,     'h1008, 0, 0, 0, 0,  1, 0, 0, 0,  1, 3,  0, 0,     0, 0, 3};
    vecs[3]  = '{0, 0, 0, 0,      0,      0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  0, 0,     0, 0, 3};
    vecs[4]  = '{1, 9, 0, 'h100,  'h100c, 1, 1, 0, 0,  0, 0, 0, 0,  1, 9,  1, 'h100, 0, 0, 4};
    vecs[5]  = '{1, 10, 6, 70,    'h2000, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0,     0, 0, 4};
    vecs[6]  = '{1, 10, 6, 70,    'h2000, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  0, 0,     0, 0, 4};
    vecs[7]  = '{1, 10, 6, 70,    'h2000, 0, 0, 0, 0,  1, 1, 6, 70, 1, 10, 0, 0,     0, 0, 5};
    vecs[8]  = '{1, 11, 7, 'h300, 'h2004, 1, 0, 0, 0,  1, 0, 0, 0,  1, 11, 0, 0,     0, 0, 6};
    vecs[9]  = '{1, 7, 8, 'h55,   'h2008, 1, 1, 1, 0,  0, 0, 0, 0,  0, 0,  0, 0,     1, 7, 6};
    vecs[10] = '{0, 0, 0, 0,      0,      0, 0, 0, 0,  0, 0, 0, 0,  0, 0,  0, 0,     1, 7, 6};
    vecs[11] = '{0, 0, 0, 0,      0,      0, 0, 0, 1,  1, 0, 0, 0,  1, 7,  0, 0,     0, 0, 7};
    vecs[12] = '{0, 0, 0, 0,      0,      0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  0, 0,     0, 0, 7};

    idle(0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_model("reset");
    reset = 1'b1;

    // Directed vector table: back-to-back ALU, taken branch hold-off, branch-flagged store.
    for (int i = 0; i < 13; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive(vecs[i].v, vecs[i].tag, vecs[i].rg, vecs[i].data, vecs[i].pc,
            vecs[i].br, vecs[i].tk, vecs[i].st, vecs[i].sa);
      step();
      chk({nm, ".ack"}, 32'(bus.Retire_ack), 32'(vecs[i].e_ack));
      chk({nm, ".arf_we"}, 32'(bus.Arf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk({nm, ".arf_waddr"}, 32'(bus.Arf_waddr), 32'(vecs[i].e_waddr));
        chk({nm, ".arf_wdata"}, bus.Arf_wdata, 32'(vecs[i].e_wdata));
      end
      chk({nm, ".free"}, 32'(bus.Tag_free_valid), 32'(vecs[i].e_free));
      if (vecs[i].e_free) chk({nm, ".free_tag"}, 32'(bus.Tag_free_tag), 32'(vecs[i].e_ftag));
      chk({nm, ".flush"}, 32'(bus.Flush), 32'(vecs[i].e_flush));
      if (vecs[i].e_flush) chk({nm, ".flush_pc"}, bus.Flush_pc, 32'(vecs[i].e_fpc));
      chk({nm, ".st_valid"}, 32'(bus.St_commit_valid), 32'(vecs[i].e_stv));
      if (vecs[i].e_stv) chk({nm, ".st_tag"}, 32'(bus.St_commit_tag), 32'(vecs[i].e_sttag));
      chk({nm, ".count"}, bus.Commit_count, 32'(vecs[i].e_count));
      check_model(nm);
    end

    // Store tag 7, ack withheld 5 cycles: retire blocked, tag stable, commit on ack.
    begin
      logic [31:0] c0;
      c0 = m_count;
      drive(1, 7, 3, 0, 'h3000, 0, 0, 1, 0);
      step();
      check_model("st_acc");
      for (int k = 0; k < 5; k++) begin
        drive(1, 8, 2, 5, 'h3004, 0, 0, 0, 0);
        step();
        chk("st_wait.ack", 32'(bus.Retire_ack), 32'd0);
        chk("st_wait.tag", 32'(bus.St_commit_tag), 32'd7);
        chk("st_wait.valid", 32'(bus.St_commit_valid), 32'd1);
        check_model("st_wait");
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      chk("st_ack.free_tag", 32'(bus.Tag_free_tag), 32'd7);
      chk("st_ack.count", bus.Commit_count, c0 + 32'd1);
      chk("st_ack.last_pc", bus.Last_commit_pc, 32'h3000);
      check_model("st_ack");
      idle(0);
      step();
      check_model("st_after");
    end

    // Timeout: ack withheld 70 cycles; Error sets on the 64th wait cycle and is sticky.
    do_reset("rst_b");
    drive(1, 3, 0, 0, 'h4000, 0, 0, 1, 0);
    step();
    for (int k = 1; k <= 70; k++) begin
      idle(0);
      step();
      chk($sformatf("to%0d.error", k), 32'(bus.Error), 32'(k >= int'(ST_TIMEOUT)));
      check_model("to");
    end
    idle(1);
    step();
    chk("to_ack.error", 32'(bus.Error), 32'd1);
    check_model("to_ack");
    idle(0);
    step();
    check_model("to_after");
    do_reset("rst_to");

    // Reset in the middle of a store wait.
    drive(1, 4, 9, 'h99, 'h5000, 0, 0, 0, 0);
    step();
    drive(1, 5, 10, 'h98, 'h5004, 0, 0, 0, 0);
    step();
    drive(1, 12, 0, 0, 'h5008, 0, 0, 1, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      idle(0);
      step();
    end
    check_model("pre_rst");
    do_reset("rst_mid");
    idle(0);
    step();
    check_model("post_rst");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom), int'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 4);
      step();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- In-order commit stage directly downstream of the ROB; consumes the ROB retire bus one entry per cycle.
- Writes results to the architectural register file (ARF) and releases committed stores to the store buffer via a valid/ack handshake.
- Signals a pipeline flush with a redirect PC on a taken branch, which the front end predicts not-taken.
- Returns each committed tag to the tag free-list and keeps a commit counter.

Parameters:
FLUSH_CYCLES, 2, cycles the FLUSH state holds off retire after a flush pulse (>=1)
ST_TIMEOUT, 64, STORE_WAIT cycles without ack before sticky Error is set
TAG_W, 5, ROB tag width
REG_W, 5, architectural register index width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
Retire_valid  in  1  ROB head entry is complete and ready to retire
Retire_rd_tag  in  TAG_W  ROB tag of head entry
Retire_rd_reg  in  REG_W  destination architectural register
Retire_data  in  32  result; for branches, the branch target
Retire_pc  in  32  PC of head instruction
Retire_branch  in  1  head is a branch
Retire_branch_taken  in  1  branch resolved taken
Retire_store_ready  in  1  head is a store, ready to commit
Retire_ack  out  1  commit unit accepts head this cycle (combinational)
Arf_we  out  1  ARF write enable
Arf_waddr  out  REG_W  ARF write address
Arf_wdata  out  32  ARF write data
St_commit_valid  out  1  request store buffer to commit store
St_commit_tag  out  TAG_W  tag of store being committed
St_commit_ack  in  1  store buffer accepted commit
Flush  out  1  one-cycle flush pulse
Flush_pc  out  32  redirect PC, valid with Flush
Tag_free_valid  out  1  tag returned to free-list
Tag_free_tag  out  TAG_W  returned tag
Last_commit_pc  out  32  PC of most recently committed instruction
Commit_count  out  32  committed-instruction counter
Error  out  1  sticky store-commit timeout flag

Behaviour:
- Reset (reset=0, async): state=RUN; all outputs 0, including counters, Error and Last_commit_pc. Reset in any state aborts the operation in progress; no partial commit survives.
- States: RUN, STORE_WAIT, FLUSH.
- Retire_ack = (state==RUN). An entry is accepted on a clock edge where Retire_valid & Retire_ack. All commit outputs are registered and appear the cycle after acceptance (latency 1).
- Classification priority: store > branch > ALU.
  - If Retire_store_ready=1, the entry is a store and branch flags are ignored.
- ALU entry:
  - Next cycle: Arf_we=1 (only if Retire_rd_reg!=0; r0 is never written), Arf_waddr/Arf_wdata from the entry.
  - Same cycle: Tag_free_valid=1 with the tag.
  - State stays RUN, so back-to-back commits are possible at 1 per cycle.
- Store entry:
  - Next cycle: St_commit_valid=1, St_commit_tag=tag; state goes to STORE_WAIT. No ARF write.
  - STORE_WAIT: St_commit_valid/tag held stable until an edge where St_commit_ack=1. On that edge St_commit_valid drops, Tag_free pulses and state returns to RUN.
  - Wait counter starts at 0 on entry to STORE_WAIT and increments each wait cycle. When it reaches ST_TIMEOUT, Error is set (sticky until reset) and the wait continues.
- Branch, not taken: tag freed, no flush, state stays RUN.
- Branch, taken (mispredict):
  - Next cycle: Flush=1 for exactly one cycle, Flush_pc=Retire_data, tag freed.
  - State goes to FLUSH; Retire_ack=0 for FLUSH_CYCLES cycles, counted from the Flush pulse, then RUN.
  - Entries presented by the ROB during FLUSH are ignored, not accepted.
- On every commit, in the same cycle as its commit effect:
  - Commit_count increments; it wraps modulo 2^32.
  - Last_commit_pc updates.
  - For stores, that cycle is the ack cycle.
- Arf_we, Tag_free_valid and Flush are single-cycle pulses; the registered path deasserts them when nothing commits.
- Retire_valid=0 in RUN: no outputs pulse, state unchanged.

Decomposition:
- Shared package (rob_pkg):
  - TAG_W and REG_W constants.
  - Commit state enum {RUN, STORE_WAIT, FLUSH}.
  - Retire-bus struct typedef, also used by rob.
- One sub-module, commit_wait_ctr:
  - Loadable down/up counter shared by the FLUSH hold count and the STORE_WAIT timeout.
  - Outputs: done and timeout.
- Everything else stays flat in commit_unit.

Test Plan:
1. Reset then 3 back-to-back ALU entries (tags 1,2,3; reg 4,5,0; data 40,50,60) -> Arf_we pulses for regs 4,5 only; Tag_free 1,2,3 on consecutive cycles; Commit_count=3.
2. Store tag 7; St_commit_ack held low 5 cycles then high -> Retire_ack=0 during wait; St_commit_tag=7 stable; Tag_free 7 and Commit_count+1 on ack cycle; state returns to RUN.
3. Taken branch tag 9, Retire_data=0x100, followed by a valid ALU entry -> Flush=1 exactly one cycle with Flush_pc=0x100; Retire_ack=0 for 2 cycles; ALU entry accepted afterwards.
4. Store with ack withheld for 70 cycles -> Error=1 at cycle 64 and stays 1 after ack; reset clears it.
5. Store with Retire_branch=1 and Retire_branch_taken=1 -> treated as store: no Flush, St_commit_valid=1.
6. reset asserted mid-STORE_WAIT -> St_commit_valid, Commit_count and Error go to 0 immediately; after release, state is RUN and Retire_ack=1.
